// File: rtl/rv_arith_unit_pkg.sv
// rv_arith_unit_pkg
// Shared definitions for the RV32I arithmetic core: datapath width,
// shift-amount width and the ALU operation codes driven on alu_fun.
// Codes 12-15 are unassigned and produce a zero result.
package rv_arith_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_COPY1 = 4'd10,
        ALU_COPY2 = 4'd11
    } alu_fun_e;

endpackage

// File: rtl/rv_alu.sv
// rv_alu
// Combinational RV32I ALU.
// Ports:
//   op1, op2  in  [XLEN-1:0]  operands
//   alu_fun   in  [3:0]       operation select (alu_fun_e codes)
//   result    out [XLEN-1:0]  operation result
//   eq, lt, ltu out 1         branch compare flags (only with ALU_BR_FLAGS_EN)
// Optional feature macro: ALU_BR_FLAGS_EN
module rv_alu
    import rv_arith_unit_pkg::*;
(
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      alu_fun,
    output logic [XLEN-1:0] result
`ifdef ALU_BR_FLAGS_EN
    ,
    output logic            eq,
    output logic            lt,
    output logic            ltu
`endif
);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;

    // Only the low five bits of op2 select the shift distance.
    assign shamt = op2[SHAMT_W-1:0];
    assign lt_s  = $signed(op1) < $signed(op2);
    assign lt_u  = op1 < op2;

    always_comb begin
        result = '0;
        case (alu_fun)
            ALU_ADD:   result = op1 + op2;
            ALU_SUB:   result = op1 - op2;
            ALU_SLL:   result = op1 << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:   result = op1 ^ op2;
            ALU_SRL:   result = op1 >> shamt;
            ALU_SRA:   result = $unsigned($signed(op1) >>> shamt);
            ALU_OR:    result = op1 | op2;
            ALU_AND:   result = op1 & op2;
            ALU_COPY1: result = op1;
            ALU_COPY2: result = op2;
            default:   result = '0;
        endcase
    end

`ifdef ALU_BR_FLAGS_EN
    assign eq  = (op1 == op2);
    assign lt  = lt_s;
    assign ltu = lt_u;
`endif

endmodule

// File: rtl/rv_arith_unit.sv
// rv_arith_unit
// Arithmetic core of the RV32I pipeline: sequential fetch adder, branch
// target adder, ALU and the execute/memory ALU result register.
// Ports:
//   clk, rst_n     in   clock, asynchronous active-low reset
//   pc             in   fetch PC             -> pc_plus_4 = pc + 4
//   pc_dec, offset in   decode PC, offset    -> br_target = pc_dec + offset
//   op1, op2       in   ALU operands
//   alu_fun        in   ALU operation select
//   hold           in   freeze pipeline register
//   alu_out        out  combinational ALU result
//   alu_out_q      out  registered ALU result
//   eq/lt/ltu, eq_q/lt_q/ltu_q out  branch flags and registered copies
//                                   (only with ALU_BR_FLAGS_EN)
// Optional feature macro: ALU_BR_FLAGS_EN
module rv_arith_unit
    import rv_arith_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    input  logic [XLEN-1:0] pc_dec,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      alu_fun,
    input  logic            hold,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] alu_out_q
`ifdef ALU_BR_FLAGS_EN
    ,
    output logic            eq,
    output logic            lt,
    output logic            ltu,
    output logic            eq_q,
    output logic            lt_q,
    output logic            ltu_q
`endif
);

    // Both adders wrap silently modulo 2^32.
    assign pc_plus_4 = pc + XLEN'(4);
    assign br_target = pc_dec + offset;

    rv_alu u_alu (
        .op1     (op1),
        .op2     (op2),
        .alu_fun (alu_fun),
        .result  (alu_out)
`ifdef ALU_BR_FLAGS_EN
        ,
        .eq      (eq),
        .lt      (lt),
        .ltu     (ltu)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
        end else if (!hold) begin
            alu_out_q <= alu_out;
        end
    end

`ifdef ALU_BR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            ltu_q <= 1'b0;
        end else if (!hold) begin
            eq_q  <= eq;
            lt_q  <= lt;
            ltu_q <= ltu;
        end
    end
`endif

endmodule

// File: tb/tb_rv_arith_unit.sv
// tb_rv_arith_unit
// Self-checking bench for rv_arith_unit: directed cases for adders, ALU
// codes, register hold/reset, then randomized operations compared against
// an arithmetic reference model. Flag checks are compiled in with
// ALU_BR_FLAGS_EN.
module tb_rv_arith_unit;
    import rv_arith_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] pc_plus_4;
    logic [31:0] pc_dec = '0;
    logic [31:0] offset = '0;
    logic [31:0] br_target;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [3:0]  alu_fun = '0;
    logic        hold = 1'b0;
    logic [31:0] alu_out;
    logic [31:0] alu_out_q;
`ifdef ALU_BR_FLAGS_EN
    logic        eq, lt, ltu, eq_q, lt_q, ltu_q;
    logic [2:0]  exp_flags_q = '0;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q = '0;

    always #5 clk = ~clk;

    rv_arith_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .pc_plus_4 (pc_plus_4),
        .pc_dec    (pc_dec),
        .offset    (offset),
        .br_target (br_target),
        .op1       (op1),
        .op2       (op2),
        .alu_fun   (alu_fun),
        .hold      (hold),
        .alu_out   (alu_out),
        .alu_out_q (alu_out_q)
`ifdef ALU_BR_FLAGS_EN
        ,
        .eq        (eq),
        .lt        (lt),
        .ltu       (ltu),
        .eq_q      (eq_q),
        .lt_q      (lt_q),
        .ltu_q     (ltu_q)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ALU from the operation definitions, using 64-bit arithmetic.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input int f);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        int              sh = int'(b % 32);
        longint unsigned p2 = 64'd1 << sh;
        case (f)
            0:  return 32'(ua + ub);
            1:  return 32'(ua - ub);
            2:  return 32'(ua * p2);
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (ua < ub) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return 32'(ua / p2);
            7:  return 32'(sa >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return a;
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
        logic e, s, u;
        e = (a == b);
        s = longint'($signed(a)) < longint'($signed(b));
        u = {32'd0, a} < {32'd0, b};
        return {e, s, u};
    endfunction

    // Drive one ALU operation, check combinational outputs, clock it, and
    // check the register against the model.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                         input logic h, input string tag);
        logic [31:0] e;
        @(negedge clk);
        op1 = a; op2 = b; alu_fun = f; hold = h;
        #1;
        e = ref_alu(a, b, int'(f));
        check(tag, alu_out, e);
`ifdef ALU_BR_FLAGS_EN
        check({tag, "_flags"}, {29'd0, eq, lt, ltu}, {29'd0, ref_flags(a, b)});
`endif
        @(posedge clk);
        if (!h && rst_n) begin
            exp_q = e;
`ifdef ALU_BR_FLAGS_EN
            exp_flags_q = ref_flags(a, b);
`endif
        end
        #1;
        check({tag, "_q"}, alu_out_q, exp_q);
`ifdef ALU_BR_FLAGS_EN
        check({tag, "_flags_q"}, {29'd0, eq_q, lt_q, ltu_q}, {29'd0, exp_flags_q});
`endif
    endtask

    task automatic check_pc(input logic [31:0] p, input logic [31:0] pd, input logic [31:0] off);
        pc = p; pc_dec = pd; offset = off;
        #1;
        check("pc_plus_4", pc_plus_4, 32'(({32'd0, p} + 64'd4) % 64'h1_0000_0000));
        check("br_target", br_target, 32'(({32'd0, pd} + {32'd0, off}) % 64'h1_0000_0000));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_q", alu_out_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        check_pc(32'h0000_0100, 32'h0000_0100, 32'hFFFF_FFF0);
        check("br_dir", br_target, 32'h0000_00F0);
        check_pc(32'hFFFF_FFFC, 32'h0, 32'h0);
        check("pc_wrap", pc_plus_4, 32'h0000_0000);

        drive(32'h7FFF_FFFF, 32'd1, ALU_ADD, 1'b0, "add_ovf");
        check("add_dir", alu_out, 32'h8000_0000);
        drive(32'd0, 32'd1, ALU_SUB, 1'b0, "sub");
        check("sub_dir", alu_out, 32'hFFFF_FFFF);
        drive(32'hFFFF_FFFF, 32'd1, ALU_SLT, 1'b0, "slt");
        check("slt_dir", alu_out, 32'd1);
`ifdef ALU_BR_FLAGS_EN
        check("flags_dir", {29'd0, eq, lt, ltu}, 32'b010);
        check("flags_q_dir", {29'd0, eq_q, lt_q, ltu_q}, 32'b010);
`endif
        drive(32'hFFFF_FFFF, 32'd1, ALU_SLTU, 1'b0, "sltu");
        check("sltu_dir", alu_out, 32'd0);
        drive(32'h8000_0000, 32'h0000_0024, ALU_SRA, 1'b0, "sra");
        check("sra_dir", alu_out, 32'hF800_0000);
        drive(32'h8000_0000, 32'h0000_0024, ALU_SRL, 1'b0, "srl");
        check("srl_dir", alu_out, 32'h0800_0000);
        drive(32'd1, 32'd31, ALU_SLL, 1'b0, "sll");
        check("sll_dir", alu_out, 32'h8000_0000);
        drive(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_XOR, 1'b0, "xor");
        check("xor_dir", alu_out, 32'h0FF0_0FF0);
        drive(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR, 1'b0, "or");
        check("or_dir", alu_out, 32'hFFF0_FFF0);
        drive(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 1'b0, "and");
        check("and_dir", alu_out, 32'hF000_F000);
        drive(32'h1234_5678, 32'h9ABC_DEF0, ALU_COPY1, 1'b0, "copy1");
        check("copy1_dir", alu_out, 32'h1234_5678);
        drive(32'h1234_5678, 32'h9ABC_DEF0, ALU_COPY2, 1'b0, "copy2");
        check("copy2_dir", alu_out, 32'h9ABC_DEF0);
        drive(32'h1234_5678, 32'h9ABC_DEF0, 4'd15, 1'b0, "fun15");
        check("fun15_dir", alu_out, 32'd0);

        // Register: load, hold, asynchronous reset between edges.
        drive(32'd2, 32'd3, ALU_ADD, 1'b0, "reg_load");
        check("reg_load_dir", alu_out_q, 32'd5);
        drive(32'd40, 32'd9, ALU_SUB, 1'b1, "reg_hold");
        check("reg_hold_dir", alu_out_q, 32'd5);
        @(negedge clk);
        hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", alu_out_q, 32'd0);
        check("comb_in_rst", alu_out, 32'd31);
        exp_q = '0;
`ifdef ALU_BR_FLAGS_EN
        exp_flags_q = '0;
        check("flags_rst", {29'd0, eq_q, lt_q, ltu_q}, 32'd0);
`endif
        drive(32'd7, 32'd8, ALU_ADD, 1'b0, "in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'd7, 32'd8, ALU_ADD, 1'b0, "after_rst");

        // Randomized operations with random hold and pc values.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            logic [3:0]  f;
            a = $urandom();
            b = $urandom();
            f = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = {1'b1, a[30:0]};
            drive(a, b, f, ($urandom_range(0, 3) == 0), "rand");
            if (i % 10 == 0) check_pc($urandom(), $urandom(), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/rv_arith_unit.md
# rv_arith_unit

Arithmetic core of the RV32I single-issue pipeline. It computes the sequential fetch address (PC+4), the branch/jump target (decode PC + sign-extended offset) and the RV32I ALU result. The ALU result is also captured in a pipeline register that feeds writeback, data-memory addressing and operand forwarding. It sits between the operand/immediate muxes and the execute/memory pipeline register.

## Interface
Parameters:
- none. Datapath width is fixed at 32 bits.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `pc` in 32: fetch-stage PC.
- `pc_plus_4` out 32: `pc + 4`, combinational.
- `pc_dec` in 32: PC of the instruction in decode/execute.
- `offset` in 32: sign-extended J- or B-type offset, already selected upstream.
- `br_target` out 32: `pc_dec + offset`, combinational.
- `op1` in 32: ALU operand 1.
- `op2` in 32: ALU operand 2.
- `alu_fun` in 4: operation select.
- `hold` in 1: when high, the pipeline register keeps its value.
- `alu_out` out 32: combinational ALU result.
- `alu_out_q` out 32: registered ALU result.

## Operation
- All adds are modulo 2^32. No overflow or carry outputs. Wrap-around is silent.
- `alu_fun` encoding (decimal → operation):
  - 0 ADD: `op1 + op2`
  - 1 SUB: `op1 − op2`
  - 2 SLL: `op1 << op2[4:0]`
  - 3 SLT: signed `op1 < op2` → 1, else 0
  - 4 SLTU: unsigned compare, same result format as SLT
  - 5 XOR
  - 6 SRL: logical right shift by `op2[4:0]`
  - 7 SRA: arithmetic right shift by `op2[4:0]`
  - 8 OR
  - 9 AND
  - 10 COPY1: pass `op1` (LUI path)
  - 11 COPY2: pass `op2`
  - 12–15: result 0
- Shift amounts use only `op2[4:0]`. Upper bits are ignored.
- `alu_out` is purely combinational. It has no dependency on `clk` or `rst_n`.

## Timing
- `pc_plus_4`, `br_target` and `alu_out` are valid in the same cycle as their inputs (zero latency).
- `alu_out_q`:
  - On rising `clk` with `hold`=0, loads `alu_out`.
  - With `hold`=1, keeps its value.
  - Latency from inputs to `alu_out_q` is 1 cycle.
- Reset:
  - `rst_n`=0 forces `alu_out_q` (and flag registers, if compiled in) to 0 immediately, regardless of `clk`.
  - Release is sampled on the next rising edge after deassertion.
  - Reset asserted mid-operation discards the pending value.
  - Reset overrides `hold`.
- Combinational outputs remain live during reset. Their reset value is whatever the inputs produce.

## Configuration
- Macro `ALU_BR_FLAGS_EN`.
- Defined: adds three combinational outputs, each 1 bit, for branch resolution:
  - `eq` = (`op1` == `op2`)
  - `lt` = signed `op1` < `op2`
  - `ltu` = unsigned `op1` < `op2`
- Also adds matching registered copies `eq_q`, `lt_q`, `ltu_q`. These follow the same `hold` and reset rules as `alu_out_q`.
- Undefined: these ports do not exist. Branch comparison is performed outside this block.

## Structure
- Shared package holds:
  - the 12 `alu_fun` codes as named constants (`ALU_ADD`…`ALU_COPY2`);
  - the width constants `XLEN`=32 and `SHAMT_W`=5.
- Natural sub-module: `rv_alu`, the combinational ALU (`op1`, `op2`, `alu_fun` → result, plus flags when enabled).
- The top level adds:
  - the two adders;
  - the pipeline register.

## Test plan
- PC adders:
  - `pc`=0x0000_0100 → `pc_plus_4`=0x0000_0104.
  - `pc`=0xFFFF_FFFC → `pc_plus_4`=0x0000_0000 (wrap).
  - `pc_dec`=0x100, `offset`=0xFFFF_FFF0 → `br_target`=0x0000_00F0.
- Arithmetic:
  - ADD 0x7FFF_FFFF+1 → 0x8000_0000.
  - SUB 0−1 → 0xFFFF_FFFF.
  - SLT(0xFFFF_FFFF, 1) → 1.
  - SLTU(0xFFFF_FFFF, 1) → 0.
- Shifts:
  - SRA(0x8000_0000, 0x0000_0024) uses shamt 4 → 0xF800_0000.
  - SRL with the same operands → 0x0800_0000.
  - SLL(1, 31) → 0x8000_0000.
- Logic and copy codes:
  - XOR/OR/AND of 0xF0F0_F0F0 and 0xFF00_FF00 → 0x0FF0_0FF0 / 0xFFF0_FFF0 / 0xF000_F000.
  - COPY1 returns `op1`, COPY2 returns `op2`.
  - `alu_fun`=15 → 0.
- Register:
  - ADD 2+3 with `hold`=0 → `alu_out_q`=5 after one rising edge.
  - Then `hold`=1 with new operands → stays 5.
  - `rst_n`=0 between edges → `alu_out_q`=0 immediately.
- With `ALU_BR_FLAGS_EN`: operands 0xFFFF_FFFF and 1 → `eq`=0, `lt`=1, `ltu`=0. Registered copies match after one edge.
